// File: rtl/cla_pipe_alu_if.sv
// rtl/cla_pipe_alu_if.sv - request/result handshake bundle for cla_pipe_alu
interface cla_pipe_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  // Operand source / result consumer side.
  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_pipe_alu.sv
// rtl/cla_pipe_alu.sv - three-stage carry-lookahead add/sub/accumulate unit
module cla_pipe_alu #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  cla_pipe_alu_if.slave bus
);
  localparam int NG = WIDTH / 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  logic [WIDTH-1:0] acc;

  // S1: bit-level generate/propagate of the selected operands
  logic             s1_valid;
  logic             s1_wacc;
  logic             s1_cin;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;

  // S2: bit G/P kept for the in-group carries, resolved carry into each group
  logic             s2_valid;
  logic             s2_wacc;
  logic [WIDTH-1:0] s2_g;
  logic [WIDTH-1:0] s2_p;
  logic [NG-1:0]    s2_gc;
  logic             s2_top_g;
  logic             s2_top_p;

  // S3: output register
  logic             s3_valid;
  logic [WIDTH-1:0] s3_sum;
  logic             s3_cout;
  logic             s3_ovf;

  logic             adv;
  logic             haz;
  logic             accept;
  logic             is_wacc_op;
  logic [WIDTH-1:0] acc_src;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic             op_c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_c;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign adv        = !s3_valid || bus.out_ready;
  assign is_wacc_op = (op_e'(bus.in_op) == OP_ACC) || (op_e'(bus.in_op) == OP_CLR);
  // Only an acc writer still in S1 blocks an ACC; one in S2 is forwarded below.
  assign haz        = (op_e'(bus.in_op) == OP_ACC) && s1_valid && s1_wacc;
  assign bus.in_ready = !rst && adv && !haz;
  assign accept     = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s3_valid;
  assign bus.out_sum   = s3_sum;
  assign bus.out_cout  = s3_cout;
  assign bus.out_ovf   = s3_ovf;

  // Operand mux; an ACC/CLR in S2 writes acc on the same edge a new ACC enters S1.
  always_comb begin
    acc_src = (s2_valid && s2_wacc) ? res_sum : acc;
    op_x    = bus.in_a;
    op_y    = bus.in_b;
    op_c    = bus.in_cin;
    case (op_e'(bus.in_op))
      OP_ADD: ;
      OP_SUB: begin
        op_y = ~bus.in_b;
        op_c = 1'b1;
      end
      OP_ACC: begin
        op_x = acc_src;
        op_y = bus.in_a;
      end
      OP_CLR: begin
        op_y = '0;
        op_c = 1'b0;
      end
      default: ;
    endcase
  end

  // Group G/P from S1 bits, then sum-of-products lookahead for every group carry.
  always_comb begin
    logic lk_c;
    logic lk_p;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    lk_c  = 1'b0;
    lk_p  = 1'b1;
    for (int k = 0; k < NG; k++) begin
      grp_g[k] = s1_g[4*k+3]
               | (s1_p[4*k+3] & s1_g[4*k+2])
               | (s1_p[4*k+3] & s1_p[4*k+2] & s1_g[4*k+1])
               | ((&s1_p[4*k+3 -: 3]) & s1_g[4*k]);
      grp_p[k] = &s1_p[4*k +: 4];
    end
    for (int k = 0; k < NG; k++) begin
      lk_c = 1'b0;
      lk_p = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        lk_c = lk_c | (grp_g[j] & lk_p);
        lk_p = lk_p & grp_p[j];
      end
      grp_c[k] = lk_c | (lk_p & s1_cin);
    end
  end

  // In-group lookahead from each group's resolved carry-in; flags from the top group.
  always_comb begin
    logic cc;
    logic pp;
    bit_c = '0;
    cc    = 1'b0;
    pp    = 1'b1;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        cc = 1'b0;
        pp = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          cc = cc | (s2_g[4*k+j] & pp);
          pp = pp & s2_p[4*k+j];
        end
        bit_c[4*k+i] = cc | (pp & s2_gc[k]);
      end
    end
    res_sum  = s2_p ^ bit_c;
    res_cout = s2_top_g | (s2_top_p & s2_gc[NG-1]);
    res_ovf  = bit_c[WIDTH-1] ^ res_cout;
  end

  // Valid bits, output register and accumulator; acc updates as its op enters S3.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      acc      <= '0;
      s3_sum   <= '0;
      s3_cout  <= 1'b0;
      s3_ovf   <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_sum  <= res_sum;
        s3_cout <= res_cout;
        s3_ovf  <= res_ovf;
        if (s2_wacc) begin
          acc <= res_sum;
        end
      end
    end
  end

  // Stage payloads; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_wacc  <= is_wacc_op;
      s1_cin   <= op_c;
      s1_g     <= op_x & op_y;
      s1_p     <= op_x ^ op_y;
      s2_wacc  <= s1_wacc;
      s2_g     <= s1_g;
      s2_p     <= s1_p;
      s2_gc    <= grp_c;
      s2_top_g <= grp_g[NG-1];
      s2_top_p <= grp_p[NG-1];
    end
  end
endmodule
